// File: rtl/approx_mult_err_sweep.sv
// Exhaustive error analyser for W x W approximate multipliers.
// Each (a,b) pair goes to an external multiplier in turn, and its product is
// compared with the exact a*b. The block keeps the error count, the sum of
// error distances and the maximum error distance. The operand stream and the
// returned product can be DUT_LAT cycles apart, which covers pipelined
// multipliers.
module approx_mult_err_sweep #(
   parameter int W       = 4,
   parameter int DUT_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [W-1:0]     a_out,
   output logic [W-1:0]     b_out,
   output logic             op_valid,
   input  logic [2*W-1:0]   y_in,
   output logic             busy,
   output logic             done,
   output logic [2*W:0]     err_count,
   output logic [4*W-1:0]   sum_ed,
   output logic [2*W-1:0]   max_ed
);

   localparam int PW     = 2 * W;
   localparam int N      = 1 << PW;
   localparam int LAT_CW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

   // pair_cnt is one bit wider than a pair index so that it can hold N,
   // which marks "every pair issued".
   localparam logic [PW:0]       PAIR_END   = (PW + 1)'(N);
   localparam logic [LAT_CW-1:0] DRAIN_INIT = LAT_CW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state;
   logic [PW:0]         pair_cnt;
   logic [LAT_CW-1:0]   drain_cnt;
   logic                start_edge;
   logic [PW-1:0]       prod_now;
   logic                cmp_valid;
   logic [PW-1:0]       cmp_exp;
   logic signed [PW:0]  diff;
   logic [PW-1:0]       ed;

   // A start is acted on only when no sweep is in flight.
   assign start_edge = start && ((state == S_IDLE) || (state == S_DONE));

   // Exact product of the pair currently on the operand bus.
   assign prod_now = {{W{1'b0}}, a_out} * {{W{1'b0}}, b_out};

   // Sequencer: issues one pair per cycle (b inner, a outer), then waits for the latency tail.
   // NOTE: state registers use non-blocking (<=) assignments, so every branch sees the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pair_cnt  <= '0;
         drain_cnt <= '0;
         a_out     <= '0;
         b_out     <= '0;
         op_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_SWEEP;
                  pair_cnt <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            S_SWEEP: begin
               if (pair_cnt == PAIR_END) begin
                  // The last pair was on the bus during the cycle that just ended.
                  a_out    <= '0;
                  b_out    <= '0;
                  op_valid <= 1'b0;
                  if (DUT_LAT == 0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_INIT;
                  end
               end else begin
                  a_out    <= pair_cnt[PW-1:W];
                  b_out    <= pair_cnt[W-1:0];
                  op_valid <= 1'b1;
                  pair_cnt <= pair_cnt + (PW + 1)'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - LAT_CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Align each pair's expected product with the cycle in which its y_in returns.
   generate
      if (DUT_LAT == 0) begin : g_comb
         assign cmp_valid = op_valid;
         assign cmp_exp   = prod_now;
      end else begin : g_pipe
         logic [PW:0] pipe [DUT_LAT];

         // Delay line of {valid, expected product}; it is emptied on reset and on start.
         // NOTE: this small array is reset element by element because stale valid bits would corrupt the stats.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DUT_LAT; i++) pipe[i] <= '0;
            end else if (start_edge) begin
               for (int i = 0; i < DUT_LAT; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= {op_valid, prod_now};
               for (int i = 1; i < DUT_LAT; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign cmp_valid = pipe[DUT_LAT-1][PW];
         assign cmp_exp   = pipe[DUT_LAT-1][PW-1:0];
      end
   endgenerate

   // Error distance |exact - y_in|, formed as a (2W+1)-bit signed difference.
   // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
   always_comb begin
      diff = $signed({1'b0, cmp_exp}) - $signed({1'b0, y_in});
      ed   = diff[PW] ? (~diff[PW-1:0] + PW'(1)) : diff[PW-1:0];
   end

   // Statistics accumulate while the compare stage is valid; a start clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
      end else if (start_edge) begin
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
      end else if (cmp_valid) begin
         err_count <= err_count + (PW + 1)'(ed != '0);
         sum_ed    <= sum_ed + (4 * W)'(ed);
         if (ed > max_ed) max_ed <= ed;
      end
   end

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// Bench for approx_mult_err_sweep. Three instances are used:
// W=4/L=0, W=2/L=0 and W=4/L=2. The bench provides model multipliers and
// computes the expected statistics with plain integer loops over every pair.
module tb_approx_mult_err_sweep;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // instance 0: W=4, L=0
   logic       st0, v0, busy0, done0;
   logic [3:0] a0, b0;
   logic [7:0] y0, max0;
   logic [8:0] err0;
   logic [15:0] sum0;
   // instance 1: W=2, L=0 (Kulkarni 2x2)
   logic       st1, v1, busy1, done1;
   logic [1:0] a1, b1;
   logic [3:0] y1, max1;
   logic [4:0] err1;
   logic [7:0] sum1;
   // instance 2: W=4, L=2
   logic       st2, v2, busy2, done2;
   logic [3:0] a2, b2;
   logic [7:0] y2, max2;
   logic [8:0] err2;
   logic [15:0] sum2;

   approx_mult_err_sweep #(.W(4), .DUT_LAT(0)) u_d0 (
      .clk(clk), .rst(rst), .start(st0), .a_out(a0), .b_out(b0), .op_valid(v0),
      .y_in(y0), .busy(busy0), .done(done0), .err_count(err0), .sum_ed(sum0), .max_ed(max0));
   approx_mult_err_sweep #(.W(2), .DUT_LAT(0)) u_d1 (
      .clk(clk), .rst(rst), .start(st1), .a_out(a1), .b_out(b1), .op_valid(v1),
      .y_in(y1), .busy(busy1), .done(done1), .err_count(err1), .sum_ed(sum1), .max_ed(max1));
   approx_mult_err_sweep #(.W(4), .DUT_LAT(2)) u_d2 (
      .clk(clk), .rst(rst), .start(st2), .a_out(a2), .b_out(b2), .op_valid(v2),
      .y_in(y2), .busy(busy2), .done(done2), .err_count(err2), .sum_ed(sum2), .max_ed(max2));

   // Model multipliers. Mode 0 is exact, mode 1 clears the LSB, mode 2 uses a
   // random table, and mode 3 is exact but two cycles late.
   int         mode0 = 0;
   int         mode2 = 0;
   logic [7:0] tab [256];
   logic [7:0] dl1, dl2, pl1, pl2;

   function automatic logic [7:0] model(input int mode, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = {4'b0, a} * {4'b0, b};
      case (mode)
         1:       return p & 8'hFE;
         2:       return tab[{a, b}];
         default: return p;
      endcase
   endfunction

   always @(posedge clk) begin
      dl1 <= {4'b0, a0} * {4'b0, b0};
      dl2 <= dl1;
      pl1 <= model(mode2, a2, b2);
      pl2 <= pl1;
   end

   always_comb y0 = (mode0 == 3) ? dl2 : model(mode0, a0, b0);
   always_comb y1 = (a1 == 2'd3 && b1 == 2'd3) ? 4'd7 : {2'b0, a1} * {2'b0, b1};
   assign y2 = pl2;

   // Mux over the instance under test, so one sweep task serves all three.
   int          sel = 0;
   logic        c_v, c_busy, c_done;
   logic [3:0]  c_a, c_b;
   logic [8:0]  c_err;
   logic [15:0] c_sum;
   logic [7:0]  c_max;
   always_comb begin
      c_v = v0; c_busy = busy0; c_done = done0; c_a = a0; c_b = b0;
      c_err = err0; c_sum = sum0; c_max = max0;
      case (sel)
         1: begin
            c_v = v1; c_busy = busy1; c_done = done1; c_a = {2'b0, a1}; c_b = {2'b0, b1};
            c_err = {4'b0, err1}; c_sum = {8'b0, sum1}; c_max = {4'b0, max1};
         end
         2: begin
            c_v = v2; c_busy = busy2; c_done = done2; c_a = a2; c_b = b2;
            c_err = err2; c_sum = sum2; c_max = max2;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      case (sel)
         1:       st1 = v;
         2:       st2 = v;
         default: st0 = v;
      endcase
   endtask

   // Reference statistics from plain integer arithmetic over every pair.
   task automatic ref_stats(input int mode, input int w, output int e, output int s, output int m);
      int n, a, b, ex, y, ed, pk;
      n = 1 << (2 * w);
      e = 0; s = 0; m = 0;
      for (int k = 0; k < n; k++) begin
         a  = k >> w;
         b  = k & ((1 << w) - 1);
         ex = a * b;
         if (w == 2)         y = (a == 3 && b == 3) ? 7 : ex;
         else if (mode == 1) y = ex - (ex % 2);
         else if (mode == 2) y = int'(tab[k]);
         else if (mode == 3) begin
            pk = k - 2;
            y  = (k >= 2) ? (pk >> 4) * (pk & 15) : 0;
         end
         else                y = ex;
         ed = (ex > y) ? ex - y : y - ex;
         if (ed != 0) e++;
         s += ed;
         if (ed > m) m = ed;
      end
   endtask

   int last_e, last_s, last_m;

   // One full sweep on instance 'sel'. A nonzero pulse_at raises start for
   // one cycle after that many cycles, while the sweep is in flight.
   task automatic run_sweep(input string tag, input int mode, input int pulse_at);
      int w, lat, n, e, s, m, cyc, idx, bad;
      w   = (sel == 1) ? 2 : 4;
      lat = (sel == 2) ? 2 : 0;
      n   = 1 << (2 * w);
      if (sel == 2) mode2 = mode; else mode0 = mode;
      ref_stats(mode, w, e, s, m);
      @(negedge clk) set_start(1'b1);
      @(negedge clk) set_start(1'b0);
      check({tag, "_busy_after_start"}, c_busy, 1);
      check({tag, "_done_drops"}, c_done, 0);
      check({tag, "_err_cleared"}, c_err, 0);
      cyc = 0; idx = 0; bad = 0;
      while (!c_done && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         set_start(cyc == pulse_at);
         if (c_v) begin
            if (int'(c_a) != (idx >> w) || int'(c_b) != (idx & ((1 << w) - 1))) bad++;
            idx++;
         end
      end
      set_start(1'b0);
      check({tag, "_latency"}, cyc, n + lat + 1);
      check({tag, "_pair_order"}, bad, 0);
      check({tag, "_pair_count"}, idx, n);
      check({tag, "_err_count"}, c_err, e);
      check({tag, "_sum_ed"}, c_sum, s);
      check({tag, "_max_ed"}, c_max, m);
      check({tag, "_busy_low"}, c_busy, 0);
      check({tag, "_bus_idle"}, {c_v, c_a, c_b}, 0);
      repeat (4) @(negedge clk);
      check({tag, "_done_held"}, c_done, 1);
      check({tag, "_err_held"}, c_err, e);
      last_e = e; last_s = s; last_m = m;
   endtask

   initial begin
      int pe, ps, pm;
      rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      for (int k = 0; k < 256; k++)
         tab[k] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'((k >> 4) * (k & 15));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         check($sformatf("reset_bus_%0d", i), {c_v, c_a, c_b}, 0);
         check($sformatf("reset_flags_%0d", i), {c_busy, c_done}, 0);
         check($sformatf("reset_stats_%0d", i), {c_err, c_sum, c_max}, 0);
      end
      @(negedge clk) rst = 1'b0;

      sel = 0;
      run_sweep("exact", 0, 0);
      run_sweep("lsb_mask", 1, 0);
      check("lsb_mask_literal", {last_e[8:0], last_s[15:0], last_m[7:0]}, {9'd64, 16'd64, 8'd1});
      run_sweep("random", 2, 0);
      pe = last_e; ps = last_s; pm = last_m;
      run_sweep("random_rerun", 2, 0);
      check("rerun_identical", {err0, sum0, max0}, {pe[8:0], ps[15:0], pm[7:0]});
      run_sweep("random_mid_start", 2, 100);
      run_sweep("late_model_l0", 3, 0);
      check("late_model_errors", (err0 != 0), 1);

      sel = 1;
      run_sweep("kulkarni", 0, 0);
      check("kulkarni_literal", {last_e[4:0], last_s[7:0], last_m[3:0]}, {5'd1, 8'd2, 4'd2});

      sel = 2;
      run_sweep("lat2_exact", 0, 0);
      run_sweep("lat2_random_drain_start", 2, 257);

      // Reset in the middle of a sweep, followed by a fresh full sweep.
      sel = 0; mode0 = 2;
      @(negedge clk) st0 = 1'b1;
      @(negedge clk) st0 = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_bus", {v0, a0, b0}, 0);
      check("midrst_flags", {busy0, done0, done2}, 0);
      check("midrst_stats", {err0, sum0, max0}, 0);
      @(negedge clk) rst = 1'b0;
      run_sweep("after_rst", 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
